// File: rtl/display_buttons_scanner.sv
// Scans a '165-style parallel-in/serial-out button chain, debounces it over two frames,
// and exposes state, sticky press flags and an IRQ through an Avalon-MM slave.
module display_buttons_scanner #(
    parameter int NUM_BITS = 16,
    parameter int CLK_DIV  = 25,
    parameter int SCAN_GAP = 5000,
    parameter bit INVERT   = 1'b1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                avs_s0_address,
    input  logic                avs_s0_read,
    output logic [31:0]         avs_s0_readdata,
    output logic                irq,
    output logic [NUM_BITS-1:0] buttons,
    input  logic                shiftreg_in,
    output logic                shiftreg_loadn,
    output logic                shiftreg_clk
);

    localparam int CMAX = (CLK_DIV > SCAN_GAP) ? CLK_DIV : SCAN_GAP;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int NW   = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'((SCAN_GAP > 0) ? SCAN_GAP - 1 : 0);
    localparam logic [NW-1:0] N_LAST   = NW'(NUM_BITS - 1);

    typedef enum logic [2:0] {S_LOAD, S_SETTLE, S_HIGH, S_LOW, S_DONE, S_GAP} state_t;

    state_t              state, state_nxt;
    logic [CW-1:0]       cnt, cnt_nxt;
    logic [NW-1:0]       n, n_nxt, n_inc;
    logic                sample, commit, div_end;
    logic [1:0]          sync_q;
    logic [NUM_BITS-1:0] frame_q, frame_nxt, prev_q;
    logic [NUM_BITS-1:0] btn_nxt, rise, clr, pressed, pressed_nxt;

    assign div_end = (cnt == DIV_LAST);
    assign n_inc   = n + NW'(1);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + CW'(1);
        n_nxt     = n;
        sample    = 1'b0;
        commit    = 1'b0;
        case (state)
            S_LOAD: if (div_end) begin
                state_nxt = S_SETTLE;
                cnt_nxt   = '0;
            end
            S_SETTLE: if (div_end) begin
                sample    = 1'b1;
                cnt_nxt   = '0;
                n_nxt     = '0;
                state_nxt = (N_LAST == '0) ? S_DONE : S_HIGH;
            end
            S_HIGH: if (div_end) begin
                state_nxt = S_LOW;
                cnt_nxt   = '0;
            end
            S_LOW: if (div_end) begin
                sample    = 1'b1;
                cnt_nxt   = '0;
                n_nxt     = n_inc;
                state_nxt = (n_inc == N_LAST) ? S_DONE : S_HIGH;
            end
            S_DONE: begin
                commit    = 1'b1;
                cnt_nxt   = '0;
                state_nxt = (SCAN_GAP == 0) ? S_LOAD : S_GAP;
            end
            S_GAP: if (cnt == GAP_LAST) begin
                state_nxt = S_LOAD;
                cnt_nxt   = '0;
            end
            default: begin
                state_nxt = S_LOAD;
                cnt_nxt   = '0;
            end
        endcase
    end

    // First sampled bit shifts up to the MSB by the end of the frame
    always_comb begin
        frame_nxt    = frame_q << 1;
        frame_nxt[0] = sync_q[1] ^ INVERT;
    end

    always_comb begin
        btn_nxt = buttons;
        if (commit && (frame_q == prev_q))
            btn_nxt = frame_q;
        rise        = btn_nxt & ~buttons;
        clr         = (avs_s0_read && avs_s0_address) ? '1 : '0;
        // A press landing on the clearing read survives it
        pressed_nxt = (pressed & ~clr) | rise;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= S_LOAD;
            cnt             <= '0;
            n               <= '0;
            sync_q          <= '0;
            frame_q         <= '0;
            prev_q          <= '0;
            buttons         <= '0;
            pressed         <= '0;
            irq             <= 1'b0;
            avs_s0_readdata <= '0;
            shiftreg_loadn  <= 1'b1;
            shiftreg_clk    <= 1'b0;
        end else begin
            state          <= state_nxt;
            cnt            <= cnt_nxt;
            n              <= n_nxt;
            sync_q         <= {sync_q[0], shiftreg_in};
            shiftreg_loadn <= (state != S_LOAD);
            shiftreg_clk   <= (state == S_HIGH);
            if (sample)
                frame_q <= frame_nxt;
            if (commit)
                prev_q <= frame_q;
            buttons <= btn_nxt;
            pressed <= pressed_nxt;
            irq     <= |pressed;
            if (avs_s0_read)
                avs_s0_readdata <= avs_s0_address ? 32'(pressed) : 32'(buttons);
        end
    end

endmodule
